// File: rtl/div_and_sub_pkg.sv
// -----------------------------------------------------------------------------
// div_and_sub_pkg
// Shared types, error codes and the single restoring-division step function
// used by the div_and_sub divider.
//   state_t         : FSM encoding (IDLE, SUB, DIV, DONE)
//   ERR_*           : error codes reported on err_o
//   restoring_step  : one radix-2 restoring iteration on a MAX_B_W-wide datapath
// Optional feature macro used by the block: DIV_AND_SUB_EARLY_EXIT_EN
// -----------------------------------------------------------------------------
package div_and_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_DIV0      = 2'b01;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b10;

  // Widest divisor the step function supports; callers zero-extend into it.
  localparam int MAX_B_W = 32;

  // Shift the partial remainder left by one, bringing in qbit_in, then try to
  // subtract b. Returns {next_rem, quotient_bit}. A set remainder MSB means the
  // shifted value overflowed the field, so the subtraction always succeeds.
  function automatic logic [MAX_B_W+1:0] restoring_step(
    input logic [MAX_B_W:0]   rem,
    input logic               qbit_in,
    input logic [MAX_B_W-1:0] b
  );
    logic [MAX_B_W:0]   shifted;
    logic [MAX_B_W+1:0] trial;
    shifted = {rem[MAX_B_W-1:0], qbit_in};
    trial   = {1'b0, shifted} - {2'b00, b};
    if (!rem[MAX_B_W] && trial[MAX_B_W+1]) begin
      restoring_step = {shifted, 1'b0};
    end else begin
      restoring_step = {trial[MAX_B_W:0], 1'b1};
    end
  endfunction

endpackage

// File: rtl/div_and_sub_if.sv
// -----------------------------------------------------------------------------
// div_and_sub_if
// Operand and result handshake bundle for div_and_sub.
//   Input side : valid_i, ready_o, d_i, b_i, c_i
//   Output side: valid_o, ready_i, q_o, r_o, err_o
//   master : the producer/consumer around the divider
//   slave  : the divider itself
// -----------------------------------------------------------------------------
interface div_and_sub_if #(
  parameter int B_W = 8,
  parameter int D_W = 16
);
  logic           valid_i;
  logic           ready_o;
  logic [D_W-1:0] d_i;
  logic [B_W-1:0] b_i;
  logic [B_W-1:0] c_i;
  logic           valid_o;
  logic           ready_i;
  logic [D_W-1:0] q_o;
  logic [B_W-1:0] r_o;
  logic [1:0]     err_o;

  modport master (
    output valid_i, d_i, b_i, c_i, ready_i,
    input  ready_o, valid_o, q_o, r_o, err_o
  );

  modport slave (
    input  valid_i, d_i, b_i, c_i, ready_i,
    output ready_o, valid_o, q_o, r_o, err_o
  );
endinterface

// File: rtl/div_and_sub_div_step_unit.sv
// -----------------------------------------------------------------------------
// div_step_unit
// Purely combinational single iteration of the restoring divider.
//   rem_i  : current partial remainder (B_W+1 bits)
//   qbit_i : dividend bit shifted into the remainder this iteration
//   b_i    : divisor
//   rem_o  : next partial remainder
//   qbit_o : quotient bit produced this iteration
// B_W must be smaller than MAX_B_W from the package.
// -----------------------------------------------------------------------------
module div_step_unit
  import div_and_sub_pkg::*;
#(
  parameter int B_W = 8
) (
  input  logic [B_W:0]   rem_i,
  input  logic           qbit_i,
  input  logic [B_W-1:0] b_i,
  output logic [B_W:0]   rem_o,
  output logic           qbit_o
);

  logic [MAX_B_W:0]   rem_ext;
  logic [MAX_B_W-1:0] b_ext;
  logic [MAX_B_W+1:0] step_res;
  logic [MAX_B_W-B_W-1:0] unused_step_bits;

  always_comb begin
    rem_ext           = '0;
    rem_ext[B_W:0]    = rem_i;
    b_ext             = '0;
    b_ext[B_W-1:0]    = b_i;
    step_res          = restoring_step(rem_ext, qbit_i, b_ext);
  end

  assign rem_o            = step_res[B_W+1:1];
  assign qbit_o           = step_res[0];
  // Upper bits stay zero because the remainder is always below the divisor.
  assign unused_step_bits = step_res[MAX_B_W+1:B_W+2];

endmodule

// File: rtl/div_and_sub.sv
// -----------------------------------------------------------------------------
// div_and_sub
// Recovers q = (d - c) / b and r = (d - c) mod b with a radix-2 restoring
// divider, inverting an upstream a*b + c stage.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : div_and_sub_if.slave (operand and result handshakes)
// err_o: 2'b10 when c > d (q=0, r=0), 2'b01 when b == 0 (q=all ones,
// r=low bits of d-c); underflow wins when both apply.
// Macro DIV_AND_SUB_EARLY_EXIT_EN: error results skip DIV and appear two
// cycles after accept; otherwise every operation takes D_W+2 cycles.
// -----------------------------------------------------------------------------
module div_and_sub
  import div_and_sub_pkg::*;
#(
  parameter int B_W = 8,
  parameter int D_W = 16
) (
  input logic        clk_i,
  input logic        rst_i,
  div_and_sub_if.slave bus
);

  localparam int CNT_W = (D_W > 1) ? $clog2(D_W) : 1;

  state_t         state_q, state_d;
  logic [D_W-1:0] d_q, d_d;
  logic [B_W-1:0] b_q, b_d;
  logic [B_W-1:0] c_q, c_d;
  logic [B_W:0]   rem_q, rem_d;
  logic [D_W-1:0] qreg_q, qreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]     err_q, err_d;
  logic [D_W-1:0] q_out_q, q_out_d;
  logic [B_W-1:0] r_out_q, r_out_d;
  logic [1:0]     err_out_q, err_out_d;

  logic [D_W-1:0] c_ext;
  logic [D_W-1:0] diff;
  logic           borrow;
  logic [1:0]     err_sub;
  logic [B_W:0]   rem_step;
  logic           qbit_step;
  logic [D_W-1:0] qreg_step;
  logic [1:0]     fin_err;
  logic [D_W-1:0] fin_q;
  logic [B_W-1:0] fin_r;

  div_step_unit #(.B_W(B_W)) u_step (
    .rem_i  (rem_q),
    .qbit_i (qreg_q[D_W-1]),
    .b_i    (b_q),
    .rem_o  (rem_step),
    .qbit_o (qbit_step)
  );

  assign qreg_step = {qreg_q[D_W-2:0], qbit_step};

  // Offset subtraction and error classification on the latched operands.
  always_comb begin
    c_ext          = D_W'(c_q);
    {borrow, diff} = {1'b0, d_q} - {1'b0, c_ext};
    if (borrow) begin
      err_sub = ERR_UNDERFLOW;
    end else if (b_q == '0) begin
      err_sub = ERR_DIV0;
    end else begin
      err_sub = ERR_NONE;
    end
  end

  // Final result as it will be registered on entry to DONE; error codes
  // override whatever the iterations produced.
  always_comb begin
    fin_err = err_q;
`ifdef DIV_AND_SUB_EARLY_EXIT_EN
    if (state_q == SUB) fin_err = err_sub;
`endif
    case (fin_err)
      ERR_UNDERFLOW: begin
        fin_q = '0;
        fin_r = '0;
      end
      ERR_DIV0: begin
        fin_q = '1;
        fin_r = diff[B_W-1:0];
      end
      default: begin
        fin_q = qreg_step;
        fin_r = rem_step[B_W-1:0];
      end
    endcase
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    b_d       = b_q;
    c_d       = c_q;
    rem_d     = rem_q;
    qreg_d    = qreg_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    q_out_d   = q_out_q;
    r_out_d   = r_out_q;
    err_out_d = err_out_q;
    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          d_d     = bus.d_i;
          b_d     = bus.b_i;
          c_d     = bus.c_i;
          state_d = SUB;
        end
      end
      SUB: begin
        err_d   = err_sub;
        rem_d   = '0;
        qreg_d  = diff;
        cnt_d   = CNT_W'(D_W - 1);
        state_d = DIV;
`ifdef DIV_AND_SUB_EARLY_EXIT_EN
        if (err_sub != ERR_NONE) begin
          state_d   = DONE;
          q_out_d   = fin_q;
          r_out_d   = fin_r;
          err_out_d = err_sub;
        end
`endif
      end
      DIV: begin
        rem_d  = rem_step;
        qreg_d = qreg_step;
        if (cnt_q == '0) begin
          state_d   = DONE;
          q_out_d   = fin_q;
          r_out_d   = fin_r;
          err_out_d = err_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      d_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      rem_q     <= '0;
      qreg_q    <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      q_out_q   <= '0;
      r_out_q   <= '0;
      err_out_q <= '0;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      b_q       <= b_d;
      c_q       <= c_d;
      rem_q     <= rem_d;
      qreg_q    <= qreg_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      q_out_q   <= q_out_d;
      r_out_q   <= r_out_d;
      err_out_q <= err_out_d;
    end
  end

  assign bus.ready_o = (state_q == IDLE);
  assign bus.valid_o = (state_q == DONE);
  assign bus.q_o     = q_out_q;
  assign bus.r_o     = r_out_q;
  assign bus.err_o   = err_out_q;

endmodule

// File: tb/tb_div_and_sub.sv
// -----------------------------------------------------------------------------
// tb_div_and_sub
// Self-checking bench for div_and_sub with directed and random operations,
// compared against a plain-arithmetic reference model. Honours
// DIV_AND_SUB_EARLY_EXIT_EN for the expected error latency.
// -----------------------------------------------------------------------------
module tb_div_and_sub;

  localparam int B_W    = 8;
  localparam int D_W    = 16;
  localparam int OK_LAT = D_W + 2;
`ifdef DIV_AND_SUB_EARLY_EXIT_EN
  localparam int ERR_LAT = 2;
`else
  localparam int ERR_LAT = D_W + 2;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  div_and_sub_if #(.B_W(B_W), .D_W(D_W)) bus ();

  div_and_sub #(.B_W(B_W), .D_W(D_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Reference: unsigned subtract-then-divide with the error rules applied first.
  task automatic model(input logic [D_W-1:0] d, input logic [B_W-1:0] b,
                       input logic [B_W-1:0] c, output logic [D_W-1:0] q,
                       output logic [B_W-1:0] r, output logic [1:0] err);
    int unsigned diff;
    if (int'(c) > int'(d)) begin
      err = 2'b10; q = '0; r = '0;
    end else begin
      diff = int'(d) - int'(c);
      if (b == 0) begin
        err = 2'b01; q = '1; r = B_W'(diff % 256);
      end else begin
        err = 2'b00; q = D_W'(diff / int'(b)); r = B_W'(diff % int'(b));
      end
    end
  endtask

  // Present one operand set; returns at the negedge after the accepting edge.
  task automatic send_op(input logic [D_W-1:0] d, input logic [B_W-1:0] b,
                         input logic [B_W-1:0] c);
    @(negedge clk_i);
    bus.valid_i = 1'b1;
    bus.d_i = d; bus.b_i = b; bus.c_i = c;
    @(negedge clk_i);
    bus.valid_i = 1'b0;
  endtask

  // Latency counted in cycles from the accept cycle to the first valid_o cycle.
  task automatic wait_done(output int lat);
    int cycles;
    cycles = 0;
    while (bus.valid_o !== 1'b1 && cycles < 60) begin
      @(negedge clk_i);
      cycles++;
    end
    lat = (bus.valid_o === 1'b1) ? cycles + 1 : -1;
    if (lat < 0) begin
      $display("[TB] FAIL timeout: valid_o never rose, got none want within 60 cycles");
      n_mismatched++;
      n_compared++;
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
    end
  endtask

  task automatic release_out();
    bus.ready_i = 1'b1;
    @(negedge clk_i);
    bus.ready_i = 1'b0;
  endtask

  task automatic run_checked(input string name, input logic [D_W-1:0] d,
                             input logic [B_W-1:0] b, input logic [B_W-1:0] c);
    logic [D_W-1:0] eq;
    logic [B_W-1:0] er;
    logic [1:0]     ee;
    int lat, elat;
    model(d, b, c, eq, er, ee);
    elat = (ee != 2'b00) ? ERR_LAT : OK_LAT;
    send_op(d, b, c);
    wait_done(lat);
    if (lat >= 0) begin
      n_compared++;
      if ({bus.q_o, bus.r_o, bus.err_o} !== {eq, er, ee}) begin
        n_mismatched++;
        $display("[TB] FAIL %s result d=%0d b=%0d c=%0d: got q=%0d r=%0d err=%0d, want q=%0d r=%0d err=%0d",
                 name, d, b, c, bus.q_o, bus.r_o, bus.err_o, eq, er, ee);
      end
      n_compared++;
      if (lat != elat) begin
        n_mismatched++;
        $display("[TB] FAIL %s latency d=%0d b=%0d c=%0d: got %0d want %0d", name, d, b, c, lat, elat);
      end
      release_out();
      n_compared++;
      if ({bus.valid_o, bus.ready_o} !== 2'b01) begin
        n_mismatched++;
        $display("[TB] FAIL %s return_idle: got valid_o=%b ready_o=%b want 0 1",
                 name, bus.valid_o, bus.ready_o);
      end
    end
  endtask

  task automatic test_reset();
    bus.valid_i = 1'b0; bus.ready_i = 1'b0;
    bus.d_i = '0; bus.b_i = '0; bus.c_i = '0;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    n_compared++;
    if ({bus.ready_o, bus.valid_o, bus.q_o, bus.r_o, bus.err_o} !== {1'b1, 1'b0, 26'd0}) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state: got ready=%b valid=%b q=%0d r=%0d err=%0d want 1 0 0 0 0",
               bus.ready_o, bus.valid_o, bus.q_o, bus.r_o, bus.err_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_directed();
    run_checked("exact", 16'd1000, 8'd7, 8'd20);
    n_compared++;
    if (bus.q_o !== 16'd140) begin
      n_mismatched++;
      $display("[TB] FAIL exact_q_held: got %0d want 140", bus.q_o);
    end
    run_checked("remainder", 16'd1003, 8'd7, 8'd20);
    run_checked("underflow", 16'd5, 8'd3, 8'd10);
    run_checked("div0", 16'd300, 8'd0, 8'd44);
    run_checked("both_err", 16'd3, 8'd0, 8'd9);
    run_checked("b_one", 16'd65535, 8'd1, 8'd0);
    run_checked("diff_zero", 16'd20, 8'd9, 8'd20);
    run_checked("b_max", 16'd65535, 8'd255, 8'd255);
  endtask

  task automatic test_random();
    logic [D_W-1:0] d;
    logic [B_W-1:0] b, c;
    logic [D_W-1:0] eq;
    int lat, amax, a;
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) begin
        // Golden a*b + c path: quotient must come back as a, remainder 0.
        b = B_W'($urandom_range(255, 1));
        c = B_W'($urandom_range(255, 0));
        amax = (65535 - int'(c)) / int'(b);
        a = int'($urandom_range(amax, 0));
        d = D_W'(a * int'(b) + int'(c));
        eq = D_W'(a);
        send_op(d, b, c);
        wait_done(lat);
        if (lat >= 0) begin
          n_compared++;
          if ({bus.q_o, bus.r_o, bus.err_o} !== {eq, 8'd0, 2'b00} || lat != OK_LAT) begin
            n_mismatched++;
            $display("[TB] FAIL golden a=%0d b=%0d c=%0d: got q=%0d r=%0d err=%0d lat=%0d, want q=%0d r=0 err=0 lat=%0d",
                     a, b, c, bus.q_o, bus.r_o, bus.err_o, lat, eq, OK_LAT);
          end
          release_out();
        end
      end else begin
        d = ($urandom_range(3, 0) == 0) ? D_W'($urandom_range(255, 0)) : D_W'($urandom);
        b = ($urandom_range(7, 0) == 0) ? 8'd0 : B_W'($urandom);
        c = B_W'($urandom);
        run_checked("random", d, b, c);
      end
    end
  endtask

  task automatic test_hold();
    logic [D_W-1:0] eq;
    logic [B_W-1:0] er;
    logic [1:0]     ee;
    int lat;
    model(16'd1003, 8'd7, 8'd20, eq, er, ee);
    send_op(16'd1003, 8'd7, 8'd20);
    wait_done(lat);
    if (lat >= 0) begin
      for (int i = 0; i < 20; i++) begin
        bus.valid_i = i[0];
        bus.d_i = D_W'($urandom); bus.b_i = B_W'($urandom); bus.c_i = B_W'($urandom);
        @(negedge clk_i);
        n_compared++;
        if ({bus.valid_o, bus.ready_o, bus.q_o, bus.r_o, bus.err_o} !== {2'b10, eq, er, ee}) begin
          n_mismatched++;
          $display("[TB] FAIL hold cycle %0d: got valid=%b ready=%b q=%0d r=%0d err=%0d want 1 0 %0d %0d %0d",
                   i, bus.valid_o, bus.ready_o, bus.q_o, bus.r_o, bus.err_o, eq, er, ee);
        end
      end
      bus.valid_i = 1'b0;
      release_out();
      n_compared++;
      if ({bus.valid_o, bus.ready_o} !== 2'b01) begin
        n_mismatched++;
        $display("[TB] FAIL hold_release: got valid=%b ready=%b want 0 1", bus.valid_o, bus.ready_o);
      end
    end
    // A fresh operation after the ignored pulses must still compute correctly.
    run_checked("after_hold", 16'd49, 8'd7, 8'd0);
  endtask

  task automatic test_back_to_back();
    logic [D_W+B_W+1:0] exp_q[$];
    logic [D_W+B_W+1:0] exp_v;
    logic [D_W-1:0] d, eq;
    logic [B_W-1:0] b, c, er;
    logic [1:0] ee;
    int pulse[$];
    int sent, got;
    sent = 0; got = 0;
    bus.ready_i = 1'b1;
    for (int cyc = 0; cyc < 120 && got < 3; cyc++) begin
      if (bus.valid_o === 1'b1) begin
        pulse.push_back(cyc);
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        got++;
        n_compared++;
        if ({bus.q_o, bus.r_o, bus.err_o} !== exp_v) begin
          n_mismatched++;
          $display("[TB] FAIL b2b result %0d: got %h want %h", got, {bus.q_o, bus.r_o, bus.err_o}, exp_v);
        end
      end
      if (bus.ready_o === 1'b1 && sent < 3) begin
        b = B_W'($urandom_range(255, 1));
        c = B_W'($urandom_range(255, 0));
        d = D_W'($urandom_range(65535, 255));
        model(d, b, c, eq, er, ee);
        exp_q.push_back({eq, er, ee});
        bus.d_i = d; bus.b_i = b; bus.c_i = c;
        bus.valid_i = 1'b1;
        sent++;
      end else if (bus.ready_o === 1'b1) begin
        bus.valid_i = 1'b0;
      end else begin
        bus.d_i = D_W'($urandom); bus.b_i = B_W'($urandom); bus.c_i = B_W'($urandom);
        bus.valid_i = 1'b1;
      end
      @(negedge clk_i);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    n_compared++;
    if (got != 3) begin
      n_mismatched++;
      $display("[TB] FAIL b2b count: got %0d results want 3", got);
    end else begin
      n_compared++;
      if (pulse[1] - pulse[0] != D_W + 3 || pulse[2] - pulse[1] != D_W + 3) begin
        n_mismatched++;
        $display("[TB] FAIL b2b spacing: got %0d,%0d want %0d", pulse[1] - pulse[0],
                 pulse[2] - pulse[1], D_W + 3);
      end
    end
    @(negedge clk_i);
  endtask

  task automatic test_async_reset();
    int lat;
    run_checked("pre_reset", 16'd1000, 8'd7, 8'd20);
    send_op(16'd60000, 8'd13, 8'd5);
    repeat (7) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    n_compared++;
    if ({bus.ready_o, bus.valid_o, bus.q_o, bus.r_o, bus.err_o} !== {1'b1, 1'b0, 26'd0}) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset: got ready=%b valid=%b q=%0d r=%0d err=%0d want 1 0 0 0 0",
               bus.ready_o, bus.valid_o, bus.q_o, bus.r_o, bus.err_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    // The aborted operation must never surface.
    lat = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk_i);
      if (bus.valid_o === 1'b1) lat = 1;
    end
    n_compared++;
    if (lat != 0) begin
      n_mismatched++;
      $display("[TB] FAIL aborted_output: got valid_o after reset want none");
    end
    run_checked("post_reset", 16'd49, 8'd7, 8'd0);
    n_compared++;
    if ({bus.q_o, bus.r_o} !== {16'd7, 8'd0}) begin
      n_mismatched++;
      $display("[TB] FAIL post_reset_values: got q=%0d r=%0d want 7 0", bus.q_o, bus.r_o);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
